// File: rtl/door_pkg.sv
// Shared types and default sizing for the door motor plant model and its controller.
package door_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'b00,
    RISING  = 2'b01,
    FALLING = 2'b10,
    FAULT   = 2'b11
  } door_state_e;

  localparam int POS_W_DEF    = 8;
  localparam int POS_TOP_DEF  = 200;
  localparam int STEP_DIV_DEF = 16;

  // A divider of 1 still needs a one-bit counter to stay legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/door_motor_model_if.sv
// Motor command / limit-switch bundle between door controller (master) and plant (slave).
// DOOR_OBSTRUCT_EN adds the Obstruct input and Stall output.
interface door_motor_model_if #(
  parameter int POS_W = door_pkg::POS_W_DEF
);
  logic             UP_M;
  logic             DOWN_M;
  logic             UP_MAX;
  logic             DOWN_MAX;
  logic [POS_W-1:0] POS;
  logic             Moving;
  logic             Fault;
`ifdef DOOR_OBSTRUCT_EN
  logic             Obstruct;
  logic             Stall;
`endif

  modport master (
    output UP_M, DOWN_M,
`ifdef DOOR_OBSTRUCT_EN
    output Obstruct,
    input  Stall,
`endif
    input  UP_MAX, DOWN_MAX, POS, Moving, Fault
  );

  modport slave (
    input  UP_M, DOWN_M,
`ifdef DOOR_OBSTRUCT_EN
    input  Obstruct,
    output Stall,
`endif
    output UP_MAX, DOWN_MAX, POS, Moving, Fault
  );

endinterface

// File: rtl/door_step_timer.sv
// Travel prescaler: emits a one-cycle step pulse after STEP_DIV cycles of unobstructed drive.
module door_step_timer
  import door_pkg::*;
#(
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  input  logic hold_i,
  output logic step_o
);

  localparam int               CNT_W = cnt_width(STEP_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign step_o = en_i & ~hold_i & (cnt_q == LAST);

  // Hold freezes the count so travel resumes mid-interval after an obstruction.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      cnt_d = step_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/door_motor_model.sv
// Door mechanics plant: FSM, saturating position counter and limit-switch decode.
// DOOR_OBSTRUCT_EN enables the obstruction input that stalls travel.
module door_motor_model
  import door_pkg::*;
#(
  parameter int POS_W    = POS_W_DEF,
  parameter int POS_TOP  = POS_TOP_DEF,
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  door_motor_model_if.slave bus
);

  localparam logic [POS_W-1:0] TOP = POS_W'(POS_TOP);

  door_state_e      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, pos_stepped;
  logic             moving, hold, step, take_step, clr;
  logic             up, dn, at_top, at_bot, step_top, step_bot;

  assign up     = bus.UP_M;
  assign dn     = bus.DOWN_M;
  assign moving = (state_q == RISING) || (state_q == FALLING);
  assign at_top = (pos_q == TOP);
  assign at_bot = (pos_q == '0);

`ifdef DOOR_OBSTRUCT_EN
  assign hold      = moving & bus.Obstruct;
  assign bus.Stall = hold;
`else
  assign hold      = 1'b0;
`endif

  door_step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clk_i  (CLK),
    .rst_ni (RST),
    .en_i   (moving),
    .clr_i  (clr),
    .hold_i (hold),
    .step_o (step)
  );

  // Position after a step in the current direction, saturated at both ends.
  always_comb begin
    pos_stepped = pos_q;
    if (step) begin
      if (state_q == RISING && !at_top) begin
        pos_stepped = pos_q + 1'b1;
      end else if (state_q == FALLING && !at_bot) begin
        pos_stepped = pos_q - 1'b1;
      end
    end
  end

  assign step_top = (pos_stepped == TOP);
  assign step_bot = (pos_stepped == '0);

  // While moving, a step is taken whenever exactly one command is held; the
  // new direction then chooses the next state from the post-step position.
  always_comb begin
    state_d   = state_q;
    take_step = 1'b0;
    unique case (state_q)
      STOPPED: begin
        if (up && dn)              state_d = FAULT;
        else if (up && !at_top)    state_d = RISING;
        else if (dn && !at_bot)    state_d = FALLING;
      end
      RISING, FALLING: begin
        if (up && dn) begin
          state_d = FAULT;
        end else if (!hold) begin
          if (!up && !dn) begin
            state_d = STOPPED;
          end else begin
            take_step = step;
            if (dn) state_d = step_bot ? STOPPED : FALLING;
            else    state_d = step_top ? STOPPED : RISING;
          end
        end
      end
      FAULT: begin
        if (!up && !dn) state_d = STOPPED;
      end
      default: state_d = STOPPED;
    endcase
  end

  assign clr   = (state_d != state_q);
  assign pos_d = take_step ? pos_stepped : pos_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= STOPPED;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  assign bus.POS      = pos_q;
  assign bus.UP_MAX   = at_top;
  assign bus.DOWN_MAX = at_bot;
  assign bus.Moving   = moving;
  assign bus.Fault    = (state_q == FAULT);

endmodule
